// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, rate constants and tick period helper for the snake game sequencer
//   Provides state_t (display encoding), RATE_* speed settings and period_cycles(rate, base).
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_MOVE      = 3'd2,
    ST_FOOD      = 3'd3,
    ST_SAMPLE    = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_OVER      = 3'd6
  } state_t;

  localparam logic [1:0] RATE_FAST   = 2'b00;
  localparam logic [1:0] RATE_QUICK  = 2'b01;
  localparam logic [1:0] RATE_NORMAL = 2'b10;
  localparam logic [1:0] RATE_SLOW   = 2'b11;
  localparam logic [1:0] RATE_INIT   = RATE_NORMAL;

  // Clock cycles per game tick for a given rate; base is the normal-speed period.
  function automatic logic [31:0] period_cycles(input logic [1:0] rate, input logic [31:0] base);
    logic [31:0] p;
    case (rate)
      RATE_FAST:   p = base >> 2;
      RATE_QUICK:  p = base >> 1;
      RATE_NORMAL: p = base;
      default:     p = base << 1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - N-bit rising-edge detector for level key inputs
//   Ports: clk, rst_n (sync, active low), key[N-1:0] levels in, rise[N-1:0] one-cycle edge flags out.
//   A key held high yields a single rise; rise is combinational from key and the registered previous level.
module key_edge #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key,
  output logic [N-1:0] rise
);

  logic [N-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= key;
    end
  end

  assign rise = key & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - run/pause/over controller sequencing move, food and stop sampling per game tick
//   Inputs : clk, rst_n, start/pause/faster/slower keys (levels), stop1/stop2, move_done, food_done
//   Outputs: new_game, move_req, move_en1, move_en2, food_req (one-cycle pulses), clk_rate, state,
//            game_over, error (sticky handshake timeout)
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       faster_key,
  input  logic       slower_key,
  input  logic       stop1,
  input  logic       stop2,
  input  logic       move_done,
  input  logic       food_done,
  output logic       new_game,
  output logic       move_req,
  output logic       move_en1,
  output logic       move_en2,
  output logic       food_req,
  output logic [1:0] clk_rate,
  output logic [2:0] state,
  output logic       game_over,
  output logic       error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [3:0] key_rise;
  logic start_rise, pause_rise, faster_rise, slower_rise;

  key_edge #(.N(4)) u_keys (
    .clk  (clk),
    .rst_n(rst_n),
    .key  ({slower_key, faster_key, pause_key, start_key}),
    .rise (key_rise)
  );

  assign start_rise  = key_rise[0];
  assign pause_rise  = key_rise[1];
  assign faster_rise = key_rise[2];
  assign slower_rise = key_rise[3];

  state_t           state_q, state_d;
  logic [1:0]       rate_q, rate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             dead1_q, dead1_d, dead2_q, dead2_d;
  logic             error_q, error_d, pend_q, pend_d;
  logic             new_game_q, new_game_d, move_req_q, move_req_d, food_req_q, food_req_d;
  logic             en1_q, en1_d, en2_q, en2_d;
  logic [31:0]      period_m1, cnt_ext;
  logic             tick, d1_now, d2_now;

  // Compare against the current rate every cycle so a speed-up mid-count ticks at once.
  assign period_m1 = period_cycles(rate_q, 32'(BASE_PERIOD)) - 32'd1;
  assign cnt_ext   = 32'(cnt_q);
  assign tick      = (cnt_ext >= period_m1);
  assign d1_now    = dead1_q | stop1;
  assign d2_now    = dead2_q | stop2;

  always_comb begin
    state_d    = state_q;
    rate_d     = rate_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    dead1_d    = dead1_q;
    dead2_d    = dead2_q;
    error_d    = error_q;
    pend_d     = pend_q;
    new_game_d = 1'b0;
    move_req_d = 1'b0;
    food_req_d = 1'b0;
    en1_d      = 1'b0;
    en2_d      = 1'b0;

    // Speed keys act in every state and saturate at both ends.
    if (faster_rise && !slower_rise && rate_q != RATE_FAST) begin
      rate_d = rate_q - 2'd1;
    end else if (slower_rise && !faster_rise && rate_q != RATE_SLOW) begin
      rate_d = rate_q + 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d    = ST_WAIT_TICK;
          new_game_d = 1'b1;
          cnt_d      = '0;
          dead1_d    = 1'b0;
          dead2_d    = 1'b0;
          error_d    = 1'b0;
          pend_d     = 1'b0;
        end
      end
      ST_WAIT_TICK: begin
        if (pause_rise) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          state_d    = ST_MOVE;
          cnt_d      = '0;
          tmo_d      = '0;
          move_req_d = 1'b1;
          en1_d      = ~dead1_q;
          en2_d      = ~dead2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_MOVE: begin
        if (pause_rise) pend_d = ~pend_q;
        // A done coincident with the request belongs to an earlier step; only accept it afterwards.
        if (move_done && !move_req_q) begin
          state_d    = ST_FOOD;
          tmo_d      = '0;
          food_req_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_OVER;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_FOOD: begin
        if (pause_rise) pend_d = ~pend_q;
        if (food_done && !food_req_q) begin
          state_d = ST_SAMPLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_OVER;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_SAMPLE: begin
        dead1_d = d1_now;
        dead2_d = d2_now;
        pend_d  = 1'b0;
        if (d1_now && d2_now)      state_d = ST_OVER;
        else if (pend_q ^ pause_rise) state_d = ST_PAUSE;
        else                       state_d = ST_WAIT_TICK;
      end
      ST_PAUSE: begin
        if (pause_rise) state_d = ST_WAIT_TICK;
      end
      ST_OVER: begin
        if (start_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rate_q     <= RATE_INIT;
      cnt_q      <= '0;
      tmo_q      <= '0;
      dead1_q    <= 1'b0;
      dead2_q    <= 1'b0;
      error_q    <= 1'b0;
      pend_q     <= 1'b0;
      new_game_q <= 1'b0;
      move_req_q <= 1'b0;
      food_req_q <= 1'b0;
      en1_q      <= 1'b0;
      en2_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      dead1_q    <= dead1_d;
      dead2_q    <= dead2_d;
      error_q    <= error_d;
      pend_q     <= pend_d;
      new_game_q <= new_game_d;
      move_req_q <= move_req_d;
      food_req_q <= food_req_d;
      en1_q      <= en1_d;
      en2_q      <= en2_d;
    end
  end

  assign new_game  = new_game_q;
  assign move_req  = move_req_q;
  assign move_en1  = en1_q;
  assign move_en2  = en2_q;
  assign food_req  = food_req_q;
  assign clk_rate  = rate_q;
  assign state     = state_q;
  assign game_over = (state_q == ST_OVER);
  assign error     = error_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - self-checking bench for game_sequencer
module tb_game_sequencer;

  logic       clk, rst_n;
  logic       start_key, pause_key, faster_key, slower_key;
  logic       stop1, stop2, move_done, food_done;
  logic       new_game, move_req, move_en1, move_en2, food_req;
  logic [1:0] clk_rate;
  logic [2:0] state;
  logic       game_over, error;

  int  checks   = 0;
  int  failures = 0;
  bit  hold_food = 1'b0;
  int  mp = 0;
  int  fp = 0;

  typedef struct {
    logic en1;
    logic en2;
    int   wait_cyc;
  } mv_t;
  mv_t exp_q[$];

  game_sequencer #(.BASE_PERIOD(8), .CNT_W(27), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_key (start_key),
    .pause_key (pause_key),
    .faster_key(faster_key),
    .slower_key(slower_key),
    .stop1     (stop1),
    .stop2     (stop2),
    .move_done (move_done),
    .food_done (food_done),
    .new_game  (new_game),
    .move_req  (move_req),
    .move_en1  (move_en1),
    .move_en2  (move_en2),
    .food_req  (food_req),
    .clk_rate  (clk_rate),
    .state     (state),
    .game_over (game_over),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath responder: done is high for the whole cycle two cycles after a request.
  initial begin
    move_done = 1'b0;
    food_done = 1'b0;
    forever begin
      @(negedge clk);
      move_done = 1'b0;
      food_done = 1'b0;
      if (rst_n !== 1'b1) begin
        mp = 0;
        fp = 0;
      end
      if (mp > 0) begin
        mp--;
        if (mp == 0) move_done = 1'b1;
      end
      if (fp > 0) begin
        fp--;
        if (fp == 0) food_done = 1'b1;
      end
      if (move_req === 1'b1) mp = 2;
      if (food_req === 1'b1 && !hold_food) fp = 2;
    end
  end

  task automatic press(input int which);
    case (which)
      0: start_key = 1'b1;
      1: pause_key = 1'b1;
      2: faster_key = 1'b1;
      default: slower_key = 1'b1;
    endcase
    @(negedge clk);
    start_key = 1'b0; pause_key = 1'b0; faster_key = 1'b0; slower_key = 1'b0;
    @(negedge clk);
  endtask

  // Advances to the next move_req, counting the WAIT_TICK cycles seen on the way (no comparison here).
  task automatic run_to_move(output int waited, output logic e1, output logic e2, output bit ok);
    int guard;
    waited = 0; ok = 1'b0; guard = 0; e1 = 1'bx; e2 = 1'bx;
    if (move_req === 1'b1) @(negedge clk);
    while (guard < 400) begin
      if (move_req === 1'b1) begin
        ok = 1'b1; e1 = move_en1; e2 = move_en2;
        break;
      end
      if (state === 3'd1) waited++;
      guard++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0 || clk_rate !== 2'b10 || game_over !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: state=%0d rate=%b over=%b err=%b, required 0 10 0 0", state, clk_rate, game_over, error);
    end
    checks++;
    if ({new_game, move_req, food_req, move_en1, move_en2} !== 5'b0) begin
      failures++;
      $display("FAIL reset_pulses: got %b required 00000", {new_game, move_req, food_req, move_en1, move_en2});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start();
    int w; logic e1, e2; bit ok; mv_t x;
    start_key = 1'b1;
    @(negedge clk);
    start_key = 1'b0;
    checks++;
    if (new_game !== 1'b1 || state !== 3'd1) begin
      failures++;
      $display("FAIL start_new_game: new_game=%b state=%0d, required 1 1", new_game, state);
    end
    exp_q.push_back('{1'b1, 1'b1, 8});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || e1 !== x.en1 || e2 !== x.en2 || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL first_tick: ok=%0d en=%b%b wait=%0d, required en=%b%b wait=%0d", ok, e1, e2, w, x.en1, x.en2, x.wait_cyc);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd2 || food_req !== 1'b0) begin
      failures++;
      $display("FAIL move_hold: state=%0d food_req=%b, required 2 0", state, food_req);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (food_req !== 1'b1 || state !== 3'd3) begin
      failures++;
      $display("FAIL food_after_move: food_req=%b state=%0d, required 1 3", food_req, state);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd4) begin
      failures++;
      $display("FAIL sample_state: state=%0d required 4", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL back_to_wait: state=%0d required 1", state);
    end
  endtask

  task automatic test_rate();
    int w; logic e1, e2; bit ok; mv_t x;
    logic [1:0] want_f [3];
    logic [1:0] want_s [3];
    want_f[0] = 2'b01; want_f[1] = 2'b00; want_f[2] = 2'b00;
    want_s[0] = 2'b01; want_s[1] = 2'b10; want_s[2] = 2'b11;
    exp_q.push_back('{1'b1, 1'b1, 8});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL tick_rate10: ok=%0d wait=%0d required %0d", ok, w, x.wait_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      press(2);
      checks++;
      if (clk_rate !== want_f[i]) begin
        failures++;
        $display("FAIL faster_%0d: clk_rate=%b required %b", i, clk_rate, want_f[i]);
      end
    end
    exp_q.push_back('{1'b1, 1'b1, 2});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL tick_rate00: ok=%0d wait=%0d required %0d", ok, w, x.wait_cyc);
    end
    for (int i = 0; i < 3; i++) begin
      press(3);
      checks++;
      if (clk_rate !== want_s[i]) begin
        failures++;
        $display("FAIL slower_%0d: clk_rate=%b required %b", i, clk_rate, want_s[i]);
      end
    end
    exp_q.push_back('{1'b1, 1'b1, 16});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL tick_rate11: ok=%0d wait=%0d required %0d", ok, w, x.wait_cyc);
    end
    press(3);
    checks++;
    if (clk_rate !== 2'b11) begin
      failures++;
      $display("FAIL slower_saturate: clk_rate=%b required 11", clk_rate);
    end
    press(2);
    checks++;
    if (clk_rate !== 2'b10) begin
      failures++;
      $display("FAIL back_to_normal: clk_rate=%b required 10", clk_rate);
    end
  endtask

  task automatic test_pause();
    int w; logic e1, e2; bit ok; mv_t x;
    exp_q.push_back('{1'b1, 1'b1, 8});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL pause_pre_tick: ok=%0d wait=%0d required %0d", ok, w, x.wait_cyc);
    end
    press(1);
    checks++;
    if (state !== 3'd2) begin
      failures++;
      $display("FAIL pause_deferred_move: state=%0d required 2", state);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 3'd4) begin
      failures++;
      $display("FAIL pause_deferred_sample: state=%0d required 4", state);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd5) begin
      failures++;
      $display("FAIL pause_at_sample: state=%0d required 5", state);
    end
    repeat (20) @(negedge clk);
    press(1);
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 3'd1) begin
      failures++;
      $display("FAIL resume_wait: state=%0d required 1", state);
    end
    press(1);
    checks++;
    if (state !== 3'd5) begin
      failures++;
      $display("FAIL pause_in_wait: state=%0d required 5", state);
    end
    repeat (20) @(negedge clk);
    pause_key = 1'b1;
    @(negedge clk);
    pause_key = 1'b0;
    exp_q.push_back('{1'b1, 1'b1, 3});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL resume_cnt_kept: ok=%0d wait=%0d required %0d", ok, w, x.wait_cyc);
    end
  endtask

  task automatic test_dead();
    int w; logic e1, e2; bit ok; mv_t x;
    stop1 = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 8});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || e1 !== x.en1 || e2 !== x.en2 || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL snake1_dead: ok=%0d en=%b%b wait=%0d, required en=%b%b wait=%0d", ok, e1, e2, w, x.en1, x.en2, x.wait_cyc);
    end
    stop2 = 1'b1;
    repeat (7) @(negedge clk);
    checks++;
    if (state !== 3'd6 || game_over !== 1'b1) begin
      failures++;
      $display("FAIL both_dead_over: state=%0d game_over=%b, required 6 1", state, game_over);
    end
    stop1 = 1'b0;
    stop2 = 1'b0;
    press(0);
    checks++;
    if (state !== 3'd0 || game_over !== 1'b0 || new_game !== 1'b0) begin
      failures++;
      $display("FAIL over_to_idle: state=%0d over=%b new_game=%b, required 0 0 0", state, game_over, new_game);
    end
    start_key = 1'b1;
    @(negedge clk);
    start_key = 1'b0;
    checks++;
    if (new_game !== 1'b1 || state !== 3'd1) begin
      failures++;
      $display("FAIL restart: new_game=%b state=%0d, required 1 1", new_game, state);
    end
    exp_q.push_back('{1'b1, 1'b1, 8});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || e1 !== x.en1 || e2 !== x.en2 || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL dead_cleared: ok=%0d en=%b%b wait=%0d, required en=%b%b wait=%0d", ok, e1, e2, w, x.en1, x.en2, x.wait_cyc);
    end
  endtask

  task automatic test_timeout();
    hold_food = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (food_req !== 1'b1 || state !== 3'd3) begin
      failures++;
      $display("FAIL tmo_food_req: food_req=%b state=%0d, required 1 3", food_req, state);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (error !== 1'b0 || state !== 3'd3) begin
      failures++;
      $display("FAIL tmo_early: error=%b state=%0d, required 0 3", error, state);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || state !== 3'd6 || game_over !== 1'b1) begin
      failures++;
      $display("FAIL tmo_fire: error=%b state=%0d over=%b, required 1 6 1", error, state, game_over);
    end
    hold_food = 1'b0;
    press(0);
    checks++;
    if (error !== 1'b1 || state !== 3'd0) begin
      failures++;
      $display("FAIL error_sticky: error=%b state=%0d, required 1 0", error, state);
    end
    start_key = 1'b1;
    @(negedge clk);
    start_key = 1'b0;
    checks++;
    if (error !== 1'b0 || new_game !== 1'b1) begin
      failures++;
      $display("FAIL error_cleared: error=%b new_game=%b, required 0 1", error, new_game);
    end
  endtask

  task automatic test_reset_mid();
    int w; logic e1, e2; bit ok; mv_t x; bit busy;
    exp_q.push_back('{1'b1, 1'b1, 8});
    run_to_move(w, e1, e2, ok);
    x = exp_q.pop_front();
    checks++;
    if (!ok || w !== x.wait_cyc) begin
      failures++;
      $display("FAIL rst_pre_tick: ok=%0d wait=%0d required %0d", ok, w, x.wait_cyc);
    end
    press(2);
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd3 || clk_rate !== 2'b01) begin
      failures++;
      $display("FAIL rst_pre_food: state=%0d rate=%b, required 3 01", state, clk_rate);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (state !== 3'd0 || clk_rate !== 2'b10 || error !== 1'b0 || game_over !== 1'b0 ||
        {new_game, move_req, food_req, move_en1, move_en2} !== 5'b0) begin
      failures++;
      $display("FAIL rst_mid: state=%0d rate=%b err=%b over=%b pulses=%b, required 0 10 0 0 00000",
               state, clk_rate, error, game_over, {new_game, move_req, food_req, move_en1, move_en2});
    end
    busy = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (move_req !== 1'b0 || food_req !== 1'b0 || new_game !== 1'b0 || state !== 3'd0) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL rst_quiet: activity after reset=%0d required 0", busy);
    end
    start_key = 1'b1;
    @(negedge clk);
    start_key = 1'b0;
    checks++;
    if (new_game !== 1'b1 || state !== 3'd1) begin
      failures++;
      $display("FAIL rst_restart: new_game=%b state=%0d, required 1 1", new_game, state);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_key = 1'b0; pause_key = 1'b0; faster_key = 1'b0; slower_key = 1'b0;
    stop1 = 1'b0; stop2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_start();
    test_rate();
    test_pause();
    test_dead();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
